// File: rtl/dual_port_ram.sv
// Two-port byte-writable RAM with a power-on / on-demand zeroing sweep.
// Ports are blocked while the sweep runs; port A wins byte collisions on a shared write.
module dual_port_ram #(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 1 << ADDR_WIDTH,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_req,
   output logic                    ready,
   input  logic                    a_en,
   input  logic                    a_we,
   input  logic [DATA_WIDTH/8-1:0] a_be,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [DATA_WIDTH-1:0]   a_wdata,
   output logic [DATA_WIDTH-1:0]   a_rdata,
   output logic                    a_rvalid,
   input  logic                    b_en,
   input  logic                    b_we,
   input  logic [DATA_WIDTH/8-1:0] b_be,
   input  logic [ADDR_WIDTH-1:0]   b_addr,
   input  logic [DATA_WIDTH-1:0]   b_wdata,
   output logic [DATA_WIDTH-1:0]   b_rdata,
   output logic                    b_rvalid
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           clr_addr_q, clr_addr_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic          a_in_range, b_in_range;
   logic [IW-1:0] a_idx, b_idx;
   logic          a_rd, b_rd, a_wr, b_wr;

   assign ready      = (state_q == READY);
   assign a_in_range = (32'(a_addr) < 32'(DEPTH));
   assign b_in_range = (32'(b_addr) < 32'(DEPTH));
   assign a_idx      = IW'(a_addr);
   assign b_idx      = IW'(b_addr);
   assign a_rd       = ready & a_en & ~a_we;
   assign b_rd       = ready & b_en & ~b_we;
   assign a_wr       = ready & a_en & a_we & a_in_range;
   assign b_wr       = ready & b_en & b_we & b_in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      unique case (state_q)
         CLEAR: begin
            if (clr_addr_q == IW'(DEPTH - 1)) begin
               state_d    = READY;
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + IW'(1);
            end
         end
         READY: begin
            if (clr_req) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // Port B is applied before port A so that A's byte lanes take precedence.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) mem_q[clr_addr_q] <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
         if (b_wr && b_be[i]) mem_q[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
         if (a_wr && a_be[i]) mem_q[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
   end

   generate
      if (READ_LATENCY == 0) begin : g_lat0
         assign a_rdata  = a_in_range ? mem_q[a_idx] : '0;
         assign b_rdata  = b_in_range ? mem_q[b_idx] : '0;
         assign a_rvalid = a_rd;
         assign b_rvalid = b_rd;
      end else begin : g_lat1
         logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
         logic                  a_rvalid_q, b_rvalid_q;

         // Sampling the array before this edge's writes land gives read-first behaviour.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_rdata_q  <= '0;
               b_rdata_q  <= '0;
               a_rvalid_q <= 1'b0;
               b_rvalid_q <= 1'b0;
            end else begin
               a_rvalid_q <= a_rd;
               b_rvalid_q <= b_rd;
               if (a_rd) a_rdata_q <= a_in_range ? mem_q[a_idx] : '0;
               if (b_rd) b_rdata_q <= b_in_range ? mem_q[b_idx] : '0;
            end
         end

         assign a_rdata  = a_rdata_q;
         assign b_rdata  = b_rdata_q;
         assign a_rvalid = a_rvalid_q;
         assign b_rvalid = b_rvalid_q;
      end
   endgenerate

endmodule

// File: tb/tb_dual_port_ram.sv
// Randomized and directed bench for dual_port_ram against an array-based reference model.
module tb_dual_port_ram;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clr_req;
   logic        ready;
   logic        a_en, a_we, b_en, b_we;
   logic [3:0]  a_be, b_be;
   logic [7:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
   logic        a_rvalid, b_rvalid;

   dual_port_ram #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .DEPTH(DEPTH),
      .READ_LATENCY(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
      .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_rdata(b_rdata), .b_rvalid(b_rvalid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: a clear request zeroes the whole array at once and
   // simply blocks the ports for DEPTH cycles.
   logic [31:0] ref_mem [DEPTH];
   logic        exp_ready;
   int          sweep_left;
   logic [31:0] exp_a_rdata, exp_b_rdata;
   logic        exp_a_rv, exp_b_rv;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
   endtask

   task automatic model_reset();
      exp_ready   = 1'b0;
      sweep_left  = DEPTH;
      exp_a_rdata = '0;
      exp_b_rdata = '0;
      exp_a_rv    = 1'b0;
      exp_b_rv    = 1'b0;
      foreach (ref_mem[k]) ref_mem[k] = '0;
   endtask

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
      end else if (exp_ready) begin
         exp_a_rv = a_en && !a_we;
         exp_b_rv = b_en && !b_we;
         if (exp_a_rv) exp_a_rdata = ref_mem[a_addr];
         if (exp_b_rv) exp_b_rdata = ref_mem[b_addr];
         for (int i = 0; i < 4; i++) begin
            if (b_en && b_we && b_be[i]) ref_mem[b_addr][8*i +: 8] = b_wdata[8*i +: 8];
         end
         for (int i = 0; i < 4; i++) begin
            if (a_en && a_we && a_be[i]) ref_mem[a_addr][8*i +: 8] = a_wdata[8*i +: 8];
         end
         if (clr_req) begin
            exp_ready  = 1'b0;
            sweep_left = DEPTH;
            foreach (ref_mem[k]) ref_mem[k] = '0;
         end
      end else begin
         exp_a_rv = 1'b0;
         exp_b_rv = 1'b0;
         sweep_left--;
         if (sweep_left == 0) exp_ready = 1'b1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("ready",    32'(ready),    32'(exp_ready));
      chk("a_rvalid", 32'(a_rvalid), 32'(exp_a_rv));
      chk("a_rdata",  a_rdata,       exp_a_rdata);
      chk("b_rvalid", 32'(b_rvalid), 32'(exp_b_rv));
      chk("b_rdata",  b_rdata,       exp_b_rdata);
   endtask

   task automatic idle();
      clr_req = 1'b0;
      a_en = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0;
      b_en = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic set_a(input logic en, input logic we, input logic [3:0] be,
                        input logic [7:0] addr, input logic [31:0] d);
      a_en = en; a_we = we; a_be = be; a_addr = addr; a_wdata = d;
   endtask

   task automatic set_b(input logic en, input logic we, input logic [3:0] be,
                        input logic [7:0] addr, input logic [31:0] d);
      b_en = en; b_we = we; b_be = be; b_addr = addr; b_wdata = d;
   endtask

   task automatic rand_ports();
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)), $urandom);
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)), $urandom);
   endtask

   task automatic wait_ready(input string tag, input int expected);
      int n = 0;
      while (ready !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'(expected));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"},    32'(ready),    32'd0);
      chk({tag, "_a_rvalid"}, 32'(a_rvalid), 32'd0);
      chk({tag, "_a_rdata"},  a_rdata,       32'd0);
      chk({tag, "_b_rvalid"}, 32'(b_rvalid), 32'd0);
      chk({tag, "_b_rdata"},  b_rdata,       32'd0);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      idle();
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_reset_outputs("por");
      repeat (3) tick();
      rst_n = 1'b1;
      wait_ready("por_sweep_len", DEPTH);

      // Freshly swept memory reads as zero
      set_a(1, 0, 4'h0, 8'd0, '0);
      set_b(1, 0, 4'h0, 8'd128, '0);
      tick();
      chk("zero_a0",   a_rdata, 32'h0);
      chk("zero_b128", b_rdata, 32'h0);
      set_a(1, 0, 4'h0, 8'd255, '0);
      idle(); set_a(1, 0, 4'h0, 8'd255, '0);
      tick();
      chk("zero_a255", a_rdata, 32'h0);

      // Byte-strobe merge, rvalid for exactly one cycle
      idle(); set_a(1, 1, 4'hF, 8'd5, 32'hDEADBEEF); tick();
      idle(); set_a(1, 1, 4'h3, 8'd5, 32'h00001234); tick();
      idle(); set_b(1, 0, 4'h0, 8'd5, '0);            tick();
      chk("be_merge", b_rdata, 32'hDEAD1234);
      chk("rv_one",   32'(b_rvalid), 32'd1);
      idle(); tick();
      chk("rv_drop",  32'(b_rvalid), 32'd0);
      idle(); set_a(1, 1, 4'hF, 8'd6, 32'hCAFEF00D); tick();
      idle(); set_a(1, 1, 4'h0, 8'd6, 32'h0); tick();
      idle(); set_a(1, 0, 4'h0, 8'd6, '0); tick();
      chk("be_none", a_rdata, 32'hCAFEF00D);

      // Same-address dual write: A wins shared lanes
      idle(); set_a(1, 1, 4'hF, 8'd9, 32'h11111111); set_b(1, 1, 4'hC, 8'd9, 32'h22222222); tick();
      idle(); set_a(1, 0, 4'h0, 8'd9, '0); tick();
      chk("coll_full", a_rdata, 32'h11111111);
      idle(); set_a(1, 1, 4'h3, 8'd9, 32'h11111111); set_b(1, 1, 4'hC, 8'd9, 32'h22222222); tick();
      idle(); set_a(1, 0, 4'h0, 8'd9, '0); tick();
      chk("coll_split", a_rdata, 32'h22221111);

      // Read-first on cross-port read-during-write
      idle(); set_a(1, 1, 4'hF, 8'd3, 32'hAAAA0000); tick();
      idle(); set_a(1, 1, 4'hF, 8'd3, 32'h00005555); set_b(1, 0, 4'h0, 8'd3, '0); tick();
      chk("rdw_old", b_rdata, 32'hAAAA0000);
      idle(); set_b(1, 0, 4'h0, 8'd3, '0); tick();
      chk("rdw_new", b_rdata, 32'h00005555);

      // Random traffic, with occasional clear requests
      for (int i = 0; i < 1500; i++) begin
         rand_ports();
         clr_req = ($urandom_range(0, 299) == 0);
         tick();
      end
      idle();
      n = 0;
      while (ready !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      if (ready !== 1'b1) chk("rand_settle", 32'(ready), 32'd1);

      // Clear sweep ignores a second request and all port traffic
      idle(); set_a(1, 1, 4'hF, 8'd200, 32'hFFFFFFFF); tick();
      idle(); set_b(1, 0, 4'h0, 8'd200, '0); tick();
      chk("pre_clr", b_rdata, 32'hFFFFFFFF);
      idle(); clr_req = 1'b1; tick();
      n = 0;
      while (ready !== 1'b1 && n < 1000) begin
         rand_ports();
         clr_req = (n == 10);
         tick();
         n++;
      end
      chk("clr_len", 32'(n), 32'(DEPTH));
      idle(); set_b(1, 0, 4'h0, 8'd200, '0); tick();
      chk("post_clr", b_rdata, 32'h0);

      // Reset in the middle of a read
      idle(); set_a(1, 1, 4'hF, 8'd7, 32'h12345678); tick();
      idle(); set_a(1, 0, 4'h0, 8'd7, '0); set_b(1, 0, 4'h0, 8'd7, '0); tick();
      chk("pre_rst_rv", 32'(a_rvalid), 32'd1);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_reset_outputs("rst_access");
      idle();
      repeat (2) tick();
      rst_n = 1'b1;
      wait_ready("rst_access_sweep", DEPTH);

      // Reset 100 cycles into a sweep restarts it from scratch
      idle(); clr_req = 1'b1; tick();
      idle();
      repeat (100) tick();
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_reset_outputs("rst_sweep");
      tick();
      rst_n = 1'b1;
      wait_ready("rst_sweep_len", DEPTH);
      idle(); set_a(1, 0, 4'h0, 8'd7, '0); tick();
      chk("post_rst_mem", a_rdata, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word-address width of both ports.
REQ-002 Parameter DATA_WIDTH, default 32, word width; SHALL be a multiple of 8.
REQ-003 Parameter DEPTH, default 1<<ADDR_WIDTH, number of words.
REQ-004 Parameter READ_LATENCY, default 1, read latency in cycles; legal values 0 and 1.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 clr_req  in  1  pulse; requests a full-memory clear sweep.
REQ-008 ready  out  1  high when the memory accepts port accesses.
REQ-009 a_en, b_en  in  1  per-port access enable.
REQ-010 a_we, b_we  in  1  per-port write enable; qualified by x_en.
REQ-011 a_be, b_be  in  DATA_WIDTH/8  per-port byte strobes; bit i covers data bits [8i+7:8i].
REQ-012 a_addr, b_addr  in  ADDR_WIDTH  per-port word address.
REQ-013 a_wdata, b_wdata  in  DATA_WIDTH  per-port write data.
REQ-014 a_rdata, b_rdata  out  DATA_WIDTH  per-port read data.
REQ-015 a_rvalid, b_rvalid  out  1  per-port read-data-valid strobe.

Function
REQ-016 Clear FSM states: CLEAR, READY; no other states.
REQ-017 CLEAR: write all-zero to word clr_addr; clr_addr increments by 1 each cycle starting at 0; at clr_addr==DEPTH-1 the FSM moves to READY on the next edge.
REQ-018 A full sweep SHALL take exactly DEPTH cycles.
REQ-019 READY: ready=1; clr_req=1 moves to CLEAR with clr_addr=0 on the next edge.
REQ-020 clr_req asserted during CLEAR SHALL be ignored; the sweep is not restarted.
REQ-021 While ready=0, port enables SHALL be ignored: no writes, and x_rvalid stays 0.
REQ-022 Write: x_en&x_we&ready at an edge updates only the bytes whose x_be bit is 1; other bytes keep their value.
REQ-023 A write with x_be all-zero SHALL leave memory unchanged.
REQ-024 Read: x_en&!x_we&ready is a read of x_addr.
REQ-025 READ_LATENCY=1: x_rdata registered at the edge of the request; x_rvalid=1 for exactly the following cycle; x_rdata holds its last value otherwise.
REQ-026 READ_LATENCY=0: x_rdata = mem[x_addr] combinationally; x_rvalid = x_en&!x_we&ready combinationally.
REQ-027 Read-during-write at the same address (either port, same edge), READ_LATENCY=1: the read returns old data (read-first).
REQ-028 Both ports write the same address on the same edge: for each byte enabled on both ports, port A data wins; bytes enabled on only one port take that port's data.
REQ-029 Out-of-range address (addr >= DEPTH when DEPTH < 2^ADDR_WIDTH): writes ignored, reads return zero.
REQ-030 Ports A and B SHALL be fully independent otherwise; both may access any address each cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force state CLEAR, clr_addr=0, ready=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0 (registered outputs).
REQ-032 After rst_n deasserts, the sweep starts on the first rising edge; ready rises after DEPTH cycles.
REQ-033 Reset asserted mid-sweep or mid-access SHALL abort it; the sweep restarts from address 0 after release.
REQ-034 Memory contents are not reset directly; they are zeroed only by the sweep.

Verification
REQ-035 Release reset (DEPTH=256) -> ready=0 for 256 cycles, then 1; reads of addresses 0, 128, 255 return 0x00000000.
REQ-036 A writes 0xDEADBEEF to 5 with be=4'b1111, then be=4'b0011 with 0x00001234; B reads 5 -> b_rdata=0xDEAD1234, b_rvalid=1 exactly one cycle after the request.
REQ-037 Same edge: A writes 0x11111111 be=4'b1111, B writes 0x22222222 be=4'b1100 to address 9; read 9 -> 0x11111111; repeat with A be=4'b0011 -> 0x22221111.
REQ-038 Address 3 holds 0xAAAA0000; A writes 0x5555 while B reads 3 on the same edge -> b_rdata=0xAAAA0000; next read -> 0x00005555.
REQ-039 Write 0xFFFFFFFF to 200, pulse clr_req, pulse clr_req again at sweep cycle 10 -> ready low exactly 256 cycles; no access effects while low; read 200 -> 0.
REQ-040 Assert rst_n=0 at sweep cycle 100 -> ready, rvalid, rdata 0 immediately; after release, ready rises after a full 256 cycles.
